// File: rtl/histogram_bin_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// histogram_bin_accumulator_pkg
// Shared constants and the controller state type for the time-correlation
// histogram path. ADDRESS_ZERO is the bin the interval distributer uses for
// zero time offset. It is kept here so both blocks agree on it.
// ---------------------------------------------------------------------------
package histogram_bin_accumulator_pkg;

  localparam int NUM_BINS     = 128;
  localparam int ADDR_W       = 7;
  localparam int COUNT_W      = 32;
  localparam int ADDRESS_ZERO = 64;

  typedef enum logic [2:0] {
    IDLE,
    INC_RD,
    INC_WR,
    RD_RD,
    RD_OUT,
    CLR
  } state_e;

endpackage

// File: rtl/histogram_bin_accumulator_hist_bin_ram.sv
// ---------------------------------------------------------------------------
// hist_bin_ram
// Single-port synchronous RAM holding the histogram bins. The read is
// registered and has 1-cycle latency. The contents are not reset, so the
// array maps onto block RAM.
// Ports:
//   clk      system clock
//   we_i     write enable: wdata_i is written to addr_i
//   addr_i   shared read/write address
//   wdata_i  write data
//   rdata_o  registered read data; this port returns the old value on a write
// ---------------------------------------------------------------------------
module hist_bin_ram
  import histogram_bin_accumulator_pkg::*;
#(
  parameter int DEPTH = NUM_BINS,
  parameter int WIDTH = COUNT_W,
  parameter int AW    = ADDR_W
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/histogram_bin_accumulator.sv
// ---------------------------------------------------------------------------
// histogram_bin_accumulator
// Counts timing events into a 128-bin histogram. Each rising edge of
// Memory_add increments the bin that Addr selects. The block does a
// read-modify-write into hist_bin_ram for each edge. The block also provides
// a single-bin host readout and a sweep that clears the whole histogram.
// Ports:
//   clk, rst_n     clock; asynchronous active-low reset
//   Addr           bin address, captured on the Memory_add rising edge
//   Memory_add     add request level; each rising edge gives one increment
//   clear          one-cycle pulse that zeroes every bin
//   rd_req/rd_addr readout request and bin address
//   rd_valid       one-cycle pulse while rd_data holds the requested bin
//   rd_data        bin value; it holds the last read value between reads
//   busy           controller active, or an add/clear still to be served
//   overflow       sticky flag: an add was dropped; only clear or reset
//                  clears it
// Build option: define HIST_SATURATE_EN to make the increment saturate at
// all-ones. Without it the increment wraps modulo 2^COUNT_W.
// ---------------------------------------------------------------------------
module histogram_bin_accumulator
  import histogram_bin_accumulator_pkg::*;
#(
  parameter int NUM_BINS = 128,
  parameter int COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  Addr,
  input  logic               Memory_add,
  input  logic               clear,
  input  logic               rd_req,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic               rd_valid,
  output logic [COUNT_W-1:0] rd_data,
  output logic               busy,
  output logic               overflow
);

  localparam logic [COUNT_W-1:0] COUNT_ONE = 1;

  state_e              state_q, state_d;
  logic                mem_add_q;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic                pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic                clr_pend_q, clr_pend_d;
  logic                overflow_q, overflow_d;
  logic [ADDR_W-1:0]   sw_q, sw_d;
  logic [COUNT_W-1:0]  rd_data_q, rd_data_d;

  logic                add_ev;
  logic                clr_req;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [COUNT_W-1:0]  ram_wdata;
  logic [COUNT_W-1:0]  ram_rdata;
  logic [COUNT_W-1:0]  inc_val;

  assign add_ev  = Memory_add & ~mem_add_q;
  // A clear that arrived while the controller was busy is held in
  // clr_pend_q. It acts on the same terms as a fresh pulse.
  assign clr_req = clear | clr_pend_q;

`ifdef HIST_SATURATE_EN
  assign inc_val = (&ram_rdata) ? ram_rdata : ram_rdata + COUNT_ONE;
`else
  assign inc_val = ram_rdata + COUNT_ONE;
`endif

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    clr_pend_d   = clr_pend_q;
    overflow_d   = overflow_q;
    sw_d         = sw_q;
    rd_data_d    = rd_data_q;
    ram_we       = 1'b0;
    ram_addr     = cur_addr_q;
    ram_wdata    = '0;

    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          // The sweep discards any queued add and any add arriving now.
          state_d      = CLR;
          sw_d         = '0;
          clr_pend_d   = 1'b0;
          pend_valid_d = 1'b0;
        end else if (pend_valid_q) begin
          state_d      = INC_RD;
          cur_addr_d   = pend_addr_q;
          // The buffer frees as it is served, so a concurrent edge refills it.
          pend_valid_d = add_ev;
          if (add_ev) begin
            pend_addr_d = Addr;
          end
        end else if (add_ev) begin
          state_d    = INC_RD;
          cur_addr_d = Addr;
        end else if (rd_req) begin
          state_d    = RD_RD;
          cur_addr_d = rd_addr;
        end
      end
      INC_RD: state_d = INC_WR;
      INC_WR: begin
        ram_we    = 1'b1;
        ram_wdata = inc_val;
        state_d   = IDLE;
      end
      RD_RD:  state_d = RD_OUT;
      RD_OUT: begin
        rd_data_d = ram_rdata;
        state_d   = IDLE;
      end
      CLR: begin
        ram_we   = 1'b1;
        ram_addr = sw_q;
        if (sw_q == ADDR_W'(NUM_BINS - 1)) begin
          state_d = IDLE;
        end else begin
          sw_d = sw_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      if (clear) begin
        clr_pend_d = 1'b1;
      end
      if (add_ev && !clr_req) begin
        if (!pend_valid_q) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = Addr;
        end else begin
          overflow_d = 1'b1;
        end
      end
    end

    if (clear) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_add_q    <= 1'b0;
      cur_addr_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      clr_pend_q   <= 1'b0;
      overflow_q   <= 1'b0;
      sw_q         <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      mem_add_q    <= Memory_add;
      cur_addr_q   <= cur_addr_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      clr_pend_q   <= clr_pend_d;
      overflow_q   <= overflow_d;
      sw_q         <= sw_d;
      rd_data_q    <= rd_data_d;
    end
  end

  hist_bin_ram #(
    .DEPTH (NUM_BINS),
    .WIDTH (COUNT_W),
    .AW    (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // The RAM output register drives rd_data during RD_OUT. The value is
  // captured so that rd_data stays stable after the rd_valid pulse.
  assign rd_valid = (state_q == RD_OUT);
  assign rd_data  = (state_q == RD_OUT) ? ram_rdata : rd_data_q;
  assign busy     = (state_q != IDLE) | pend_valid_q | clr_pend_q | add_ev;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_histogram_bin_accumulator.sv
module tb_histogram_bin_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  Addr;
  logic        Memory_add;
  logic        clear;
  logic        rd_req;
  logic [6:0]  rd_addr;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        busy;
  logic        overflow;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model [128];

  always #5 clk = ~clk;

  histogram_bin_accumulator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Addr       (Addr),
    .Memory_add (Memory_add),
    .clear      (clear),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .busy       (busy),
    .overflow   (overflow)
  );

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running, required end before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected bin value after one increment, from plain arithmetic.
  function automatic logic [31:0] model_inc(input logic [31:0] v);
    logic [32:0] s;
    s = {1'b0, v} + 33'd1;
`ifdef HIST_SATURATE_EN
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
`else
    return s[31:0];
`endif
  endfunction

  task automatic model_zero();
    for (int i = 0; i < 128; i++) model[i] = '0;
  endtask

  // Every task starts and ends 2 time units after a rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 400; i++) begin
      #3;
      if (busy === 1'b0) break;
      next_cycle();
    end
    if (i == 400) check_eq("idle_timeout", {31'd0, busy}, 32'd0);
    next_cycle();
  endtask

  task automatic do_add(input logic [6:0] a, input int hold);
    $display("add  bin %0d hold %0d", a, hold);
    Memory_add = 1'b1;
    Addr       = a;
    model[a]   = model_inc(model[a]);
    for (int i = 0; i < hold; i++) begin
      next_cycle();
      Addr = 7'($urandom);
    end
    Memory_add = 1'b0;
    wait_idle();
  endtask

  task automatic do_read(input logic [6:0] a, output logic [31:0] d);
    int lat;
    int pulses;
    lat    = 0;
    pulses = 0;
    d      = '0;
    rd_req  = 1'b1;
    rd_addr = a;
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      rd_req  = 1'b0;
      rd_addr = 7'($urandom);
      #3;
      if (rd_valid === 1'b1) begin
        pulses++;
        if (lat == 0) begin
          lat = i;
          d   = rd_data;
        end
      end
    end
    next_cycle();
    check_eq("rd_latency", lat, 32'd2);
    check_eq("rd_pulses", pulses, 32'd1);
  endtask

  task automatic check_bin(input logic [6:0] a);
    logic [31:0] d;
    do_read(a, d);
    $display("read bin %0d = %h (model %h)", a, d, model[a]);
    check_eq($sformatf("bin%0d", a), d, model[a]);
  endtask

  task automatic check_all();
    for (int a = 0; a < 128; a++) check_bin(7'(a));
  endtask

  task automatic do_clear();
    $display("clear");
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
    wait_idle();
    model_zero();
  endtask

  // Issues a clear, then three add edges 2 cycles apart while the sweep runs.
  // The first edge goes to the pending buffer and the other two are dropped.
  // On return the sweep is at cycle 11.
  task automatic clear_with_adds(input logic [6:0] base);
    $display("clear with adds at %0d..%0d", base, base + 7'd2);
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
    repeat (4) next_cycle();
    for (int k = 0; k < 3; k++) begin
      Memory_add = 1'b1;
      Addr       = 7'(base + 7'(k));
      next_cycle();
      Memory_add = 1'b0;
      next_cycle();
    end
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_eq({pfx, "_busy"},     {31'd0, busy},     32'd0);
    check_eq({pfx, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
    check_eq({pfx, "_overflow"}, {31'd0, overflow}, 32'd0);
    check_eq({pfx, "_rd_data"},  rd_data,           32'd0);
  endtask

  initial begin
    logic [6:0] ra;
    int         r;

    rst_n      = 1'b0;
    Addr       = '0;
    Memory_add = 1'b0;
    clear      = 1'b0;
    rd_req     = 1'b0;
    rd_addr    = '0;
    model_zero();
    repeat (3) next_cycle();
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    next_cycle();
    do_clear();

    // A level held for 6 cycles counts once. busy falls 3 cycles after the edge.
    $display("add  bin 64 held 6 cycles");
    Memory_add = 1'b1;
    Addr       = 7'd64;
    model[64]  = model_inc(model[64]);
    #3;
    check_eq("busy_t0", {31'd0, busy}, 32'd1);
    next_cycle();
    #3;
    check_eq("busy_t1", {31'd0, busy}, 32'd1);
    next_cycle();
    #3;
    check_eq("busy_t2", {31'd0, busy}, 32'd1);
    next_cycle();
    #3;
    check_eq("busy_t3", {31'd0, busy}, 32'd0);
    repeat (3) next_cycle();
    Memory_add = 1'b0;
    wait_idle();
    check_bin(7'd64);

    // Add pulses spaced 8 cycles apart.
    for (int k = 0; k < 3; k++) begin
      ra = (k == 1) ? 7'd68 : 7'd60;
      $display("add  bin %0d pulse", ra);
      Memory_add = 1'b1;
      Addr       = ra;
      model[ra]  = model_inc(model[ra]);
      repeat (2) next_cycle();
      Memory_add = 1'b0;
      repeat (6) next_cycle();
    end
    wait_idle();
    check_bin(7'd60);
    check_bin(7'd68);
    check_bin(7'd64);
    check_eq("ovf_spaced", {31'd0, overflow}, 32'd0);

    // The edge at cycle 2 lands while the first add is in INC_WR.
    // Both later edges go through the pending buffer.
    $display("add  bin 20, then bin 10 twice via pending buffer");
    Memory_add = 1'b1; Addr = 7'd20;
    next_cycle(); Memory_add = 1'b0;
    next_cycle(); Memory_add = 1'b1; Addr = 7'd10;
    next_cycle(); Memory_add = 1'b0;
    next_cycle(); Memory_add = 1'b1; Addr = 7'd10;
    next_cycle(); Memory_add = 1'b0;
    model[20] = model_inc(model[20]);
    model[10] = model_inc(model_inc(model[10]));
    wait_idle();
    check_eq("ovf_pending", {31'd0, overflow}, 32'd0);
    check_bin(7'd10);
    check_bin(7'd20);

    // Adds during the sweep overflow the buffer. Only the first add survives.
    clear_with_adds(7'd30);
    check_eq("ovf_set", {31'd0, overflow}, 32'd1);
    wait_idle();
    model_zero();
    model[30] = 32'd1;
    check_eq("ovf_sticky", {31'd0, overflow}, 32'd1);
    check_bin(7'd30);
    check_bin(7'd31);
    $display("clear after overflow");
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
    check_eq("ovf_cleared", {31'd0, overflow}, 32'd0);
    wait_idle();
    model_zero();
    check_all();

    // Increment at the top of the counter range.
    dut.u_ram.mem_q[5] = 32'hFFFF_FFFF;
    model[5]           = 32'hFFFF_FFFF;
    do_add(7'd5, 2);
    check_bin(7'd5);
    dut.u_ram.mem_q[6] = 32'hFFFF_FFFE;
    model[6]           = 32'hFFFF_FFFE;
    do_add(7'd6, 1);
    check_bin(7'd6);

    // Random mix of adds, bursts of three adds 2 cycles apart, reads and clears.
    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 19));
      if (r < 8) begin
        do_add(7'($urandom), int'($urandom_range(1, 5)));
      end else if (r < 11) begin
        $display("burst of 3 adds");
        for (int k = 0; k < 3; k++) begin
          ra = 7'($urandom);
          Memory_add = 1'b1;
          Addr       = ra;
          model[ra]  = model_inc(model[ra]);
          next_cycle();
          Memory_add = 1'b0;
          next_cycle();
        end
        wait_idle();
      end else if (r < 19) begin
        check_bin(7'($urandom));
      end else begin
        do_clear();
      end
    end
    check_eq("ovf_random", {31'd0, overflow}, 32'd0);
    check_bin(7'd64);

    // Reset asserted while the sweep is at address 40, with overflow set.
    for (int k = 0; k < 4; k++) do_add(7'(100 + k), 1);
    clear_with_adds(7'd90);
    check_eq("ovf_before_rst", {31'd0, overflow}, 32'd1);
    repeat (30) next_cycle();
    $display("reset mid-sweep");
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    #1;
    check_eq("busy_after_rst", {31'd0, busy}, 32'd0);
    next_cycle();
    do_clear();
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
